// File: rtl/mem_pkg.sv
// Shared load/store definitions: RISC-V load funct3 codes, fault causes and
// the load unit state encoding.
package mem_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

  localparam logic [1:0] FC_NONE       = 2'b00;
  localparam logic [1:0] FC_MISALIGNED = 2'b01;
  localparam logic [1:0] FC_ILLEGAL    = 2'b10;
  localparam logic [1:0] FC_TIMEOUT    = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // LD and LWU only exist on a 64-bit datapath.
  function automatic logic f3_legal(input logic [2:0] f3, input logic xlen64);
    logic ok;
    case (f3)
      F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU: ok = 1'b1;
      F3_LD, F3_LWU:                       ok = xlen64;
      default:                             ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/load_extract.sv
// Byte-lane select plus sign/zero extension of a memory word for a load of
// the given funct3 at byte offset off within the word.
module load_extract
  import mem_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]                 funct3,
  input  logic [$clog2(XLEN/8)-1:0] off,
  input  logic [XLEN-1:0]            rdata,
  output logic [XLEN-1:0]            data
);

  localparam int OFF_W = $clog2(XLEN/8);

  logic [OFF_W+2:0] b_sh, h_sh, w_sh;
  logic [7:0]       b_f;
  logic [15:0]      h_f;
  logic [31:0]      w_f;

  always_comb begin
    // Halves and words ignore the offset bits below their own size.
    b_sh = {off, 3'b000};
    h_sh = {off & ~OFF_W'(1), 3'b000};
    w_sh = {off & ~OFF_W'(3), 3'b000};
    b_f  = 8'(rdata >> b_sh);
    h_f  = 16'(rdata >> h_sh);
    w_f  = 32'(rdata >> w_sh);
    data = rdata;
    case (funct3)
      F3_LB:   data = XLEN'($signed(b_f));
      F3_LBU:  data = XLEN'(b_f);
      F3_LH:   data = XLEN'($signed(h_f));
      F3_LHU:  data = XLEN'(h_f);
      F3_LW:   data = XLEN'($signed(w_f));
      F3_LWU:  data = XLEN'(w_f);
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_load_unit.sv
// Load unit: checks and accepts a load, runs a word-aligned read handshake
// against a multi-cycle memory, then formats the returned word.
module mem_load_unit
  import mem_pkg::*;
#(
  parameter int          XLEN        = 32,
  parameter int          ADDR_W      = 32,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_en,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic              flush,
  output logic              mem_read,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [XLEN-1:0]   mem_rdata,
  input  logic              mem_busywait,
  output logic [XLEN-1:0]   load_data,
  output logic              load_valid,
  output logic              stall,
  output logic              fault,
  output logic [1:0]        fault_cause,
  output logic [1:0]        dbg_state
);

  localparam int OFF_W = $clog2(XLEN/8);

  // Memory handshake: mem_read is held with a stable mem_addr until a cycle
  // in which mem_busywait is low; that cycle's mem_rdata is the read data.
  state_t            state;
  logic [2:0]        f3_q;
  logic [OFF_W-1:0]  off_q;
  logic              discard_q;
  logic [31:0]       wait_cnt;
  logic [OFF_W-1:0]  off;
  logic              legal, aligned, timeout_hit;
  logic [XLEN-1:0]   ext_data;

  always_comb begin
    off     = addr[OFF_W-1:0];
    legal   = f3_legal(funct3, XLEN == 64);
    case (funct3[1:0])
      2'b00:   aligned = 1'b1;
      2'b01:   aligned = ~off[0];
      2'b10:   aligned = (off[1:0] == 2'b00);
      default: aligned = (off == '0);
    endcase
    timeout_hit = (TIMEOUT_CYC != 0) && (wait_cnt == TIMEOUT_CYC - 1);
  end

  assign stall = ~reset &&
                 ((state == ST_IDLE && load_en && legal && aligned && !flush) ||
                  state == ST_READ);
  assign dbg_state = state;

  load_extract #(.XLEN(XLEN)) u_extract (
    .funct3 (f3_q),
    .off    (off_q),
    .rdata  (mem_rdata),
    .data   (ext_data)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      f3_q        <= '0;
      off_q       <= '0;
      discard_q   <= 1'b0;
      wait_cnt    <= '0;
      mem_read    <= 1'b0;
      mem_addr    <= '0;
      load_data   <= '0;
      load_valid  <= 1'b0;
      fault       <= 1'b0;
      fault_cause <= FC_NONE;
    end else begin
      fault      <= 1'b0;
      load_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (load_en && !flush) begin
            if (!legal) begin
              fault       <= 1'b1;
              fault_cause <= FC_ILLEGAL;
            end else if (!aligned) begin
              fault       <= 1'b1;
              fault_cause <= FC_MISALIGNED;
            end else begin
              f3_q      <= funct3;
              off_q     <= off;
              mem_addr  <= {addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
              mem_read  <= 1'b1;
              wait_cnt  <= '0;
              discard_q <= 1'b0;
              state     <= ST_READ;
            end
          end
        end
        ST_READ: begin
          // A flush only marks the load; the memory read still finishes.
          discard_q <= discard_q | flush;
          if (!mem_busywait) begin
            mem_read   <= 1'b0;
            load_valid <= !(discard_q || flush);
            if (!(discard_q || flush)) load_data <= ext_data;
            state      <= ST_RESP;
          end else if (timeout_hit) begin
            mem_read    <= 1'b0;
            fault       <= 1'b1;
            fault_cause <= FC_TIMEOUT;
            state       <= ST_IDLE;
          end else begin
            wait_cnt <= wait_cnt + 32'd1;
          end
        end
        ST_RESP: begin
          discard_q <= 1'b0;
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_load_unit.sv
// Bench for mem_load_unit: a 32-bit instance (short timeout) and a 64-bit
// instance, each with a busywait memory responder and a load-data scoreboard.
module tb_mem_load_unit;
  import mem_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  logic [63:0] exp_q[$];
  logic [63:0] exp64_q[$];

  // 32-bit instance
  logic        rst_a, load_en_a, flush_a, mem_read_a, load_valid_a, stall_a, fault_a;
  logic        mem_busywait_a = 1'b1;
  logic [2:0]  funct3_a;
  logic [31:0] addr_a, mem_addr_a, mem_rdata_a, load_data_a;
  logic [1:0]  fault_cause_a, dbg_state_a;
  int          busy_a = 0, rd_cnt_a = 0;

  // 64-bit instance
  logic        rst_b, load_en_b, flush_b, mem_read_b, load_valid_b, stall_b, fault_b;
  logic        mem_busywait_b = 1'b1;
  logic [2:0]  funct3_b;
  logic [31:0] addr_b, mem_addr_b;
  logic [63:0] mem_rdata_b, load_data_b;
  logic [1:0]  fault_cause_b, dbg_state_b;
  int          busy_b = 0, rd_cnt_b = 0;

  mem_load_unit #(.XLEN(32), .ADDR_W(32), .TIMEOUT_CYC(4)) dut_a (
    .clk(clk), .reset(rst_a), .load_en(load_en_a), .funct3(funct3_a), .addr(addr_a),
    .flush(flush_a), .mem_read(mem_read_a), .mem_addr(mem_addr_a),
    .mem_rdata(mem_rdata_a), .mem_busywait(mem_busywait_a), .load_data(load_data_a),
    .load_valid(load_valid_a), .stall(stall_a), .fault(fault_a),
    .fault_cause(fault_cause_a), .dbg_state(dbg_state_a)
  );

  mem_load_unit #(.XLEN(64), .ADDR_W(32), .TIMEOUT_CYC(255)) dut_b (
    .clk(clk), .reset(rst_b), .load_en(load_en_b), .funct3(funct3_b), .addr(addr_b),
    .flush(flush_b), .mem_read(mem_read_b), .mem_addr(mem_addr_b),
    .mem_rdata(mem_rdata_b), .mem_busywait(mem_busywait_b), .load_data(load_data_b),
    .load_valid(load_valid_b), .stall(stall_b), .fault(fault_b),
    .fault_cause(fault_cause_b), .dbg_state(dbg_state_b)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference formatter built byte by byte.
  function automatic logic [63:0] model(input int xlen, input logic [2:0] f3,
                                         input int off, input logic [63:0] rd);
    logic [63:0] v;
    int nb;
    case (f3[1:0])
      2'b00:   nb = 1;
      2'b01:   nb = 2;
      2'b10:   nb = 4;
      default: nb = 8;
    endcase
    v = '0;
    for (int i = 0; i < nb; i++) v[8*i +: 8] = rd[8*(off+i) +: 8];
    if (!f3[2] && v[8*nb-1])
      for (int i = nb; i < xlen/8; i++) v[8*i +: 8] = 8'hFF;
    return v;
  endfunction

  // Memory responders: busy for busy_x READ cycles, then ready.
  always @(negedge clk) begin
    if (mem_read_a) begin
      mem_busywait_a = (rd_cnt_a < busy_a);
      rd_cnt_a++;
    end else begin
      rd_cnt_a = 0;
      mem_busywait_a = 1'b1;
    end
    if (mem_read_b) begin
      mem_busywait_b = (rd_cnt_b < busy_b);
      rd_cnt_b++;
    end else begin
      rd_cnt_b = 0;
      mem_busywait_b = 1'b1;
    end
  end

  // Scoreboard monitors
  always @(negedge clk) begin
    if (!rst_a && load_valid_a) begin
      if (exp_q.size() == 0) check("unexp_valid_a", {63'b0, load_valid_a}, 64'd0);
      else check("load_data_a", {32'b0, load_data_a}, exp_q.pop_front());
    end
    if (!rst_b && load_valid_b) begin
      if (exp64_q.size() == 0) check("unexp_valid_b", {63'b0, load_valid_b}, 64'd0);
      else check("load_data_b", load_data_b, exp64_q.pop_front());
    end
  end

  task automatic run_a(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd,
                       input int busy, input logic [31:0] exp);
    int lat = 0, stall_n = 0;
    mem_rdata_a = rd;
    busy_a = busy;
    exp_q.push_back({32'b0, exp});
    @(negedge clk);
    load_en_a = 1'b1; funct3_a = f3; addr_a = a;
    #1 check("stall_accept", 64'(stall_a), 64'd1);
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i == 1) begin
        load_en_a = 1'b0;
        check("mem_read", 64'(mem_read_a), 64'd1);
        check("mem_addr", 64'(mem_addr_a), 64'(a & ~32'h3));
      end
      if (load_valid_a) begin
        lat = i;
        break;
      end
      if (stall_a) stall_n++;
    end
    check("valid_latency", 64'(lat), 64'(busy + 2));
    check("stall_cycles", 64'(stall_n), 64'(busy + 1));
    @(negedge clk);
    check("valid_pulse", 64'(load_valid_a), 64'd0);
    check("mem_read_done", 64'(mem_read_a), 64'd0);
  endtask

  task automatic run_b(input logic [2:0] f3, input logic [31:0] a, input logic [63:0] rd,
                       input logic [63:0] exp);
    int lat = 0;
    mem_rdata_b = rd;
    busy_b = 1;
    exp64_q.push_back(exp);
    @(negedge clk);
    load_en_b = 1'b1; funct3_b = f3; addr_b = a;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i == 1) begin
        load_en_b = 1'b0;
        check("mem_addr_b", 64'(mem_addr_b), 64'(a & ~32'h7));
      end
      if (load_valid_b) begin
        lat = i;
        break;
      end
    end
    check("valid_latency_b", 64'(lat), 64'd3);
    @(negedge clk);
  endtask

  task automatic fault_a_case(input logic [2:0] f3, input logic [31:0] a, input logic [1:0] cause);
    @(negedge clk);
    load_en_a = 1'b1; funct3_a = f3; addr_a = a;
    #1 check("stall_fault", 64'(stall_a), 64'd0);
    @(negedge clk);
    load_en_a = 1'b0;
    check("fault_pulse", 64'(fault_a), 64'd1);
    check("fault_cause", 64'(fault_cause_a), 64'(cause));
    check("fault_no_read", 64'(mem_read_a), 64'd0);
    check("fault_state", 64'(dbg_state_a), 64'(ST_IDLE));
    @(negedge clk);
    check("fault_one_cycle", 64'(fault_a), 64'd0);
    check("fault_cause_held", 64'(fault_cause_a), 64'(cause));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int at, rd_n, v_n, f_n;
    logic [31:0] prev;
    logic [2:0] f3s[5];
    f3s = '{F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU};

    rst_a = 1'b1; rst_b = 1'b1;
    load_en_a = 1'b1; funct3_a = F3_LW; addr_a = 32'h1000; flush_a = 1'b0; mem_rdata_a = '0;
    load_en_b = 1'b0; funct3_b = F3_LD; addr_b = 32'h0;    flush_b = 1'b0; mem_rdata_b = '0;
    repeat (2) @(negedge clk);
    check("rst_stall", 64'(stall_a), 64'd0);
    check("rst_mem_read", 64'(mem_read_a), 64'd0);
    check("rst_mem_addr", 64'(mem_addr_a), 64'd0);
    check("rst_load_data", 64'(load_data_a), 64'd0);
    check("rst_load_valid", 64'(load_valid_a), 64'd0);
    check("rst_fault", 64'(fault_a), 64'd0);
    check("rst_fault_cause", 64'(fault_cause_a), 64'd0);
    check("rst_state", 64'(dbg_state_a), 64'(ST_IDLE));
    check("rst_load_data_b", load_data_b, 64'd0);
    load_en_a = 1'b0;
    rst_a = 1'b0; rst_b = 1'b0;
    @(negedge clk);

    // Directed formatting cases
    run_a(F3_LB,  32'h1003, 32'h80FF_1234, 0, 32'hFFFF_FF80);
    run_a(F3_LBU, 32'h1003, 32'h80FF_1234, 0, 32'h0000_0080);
    run_a(F3_LH,  32'h1002, 32'h8001_7FFF, 3, 32'hFFFF_8001);
    run_a(F3_LHU, 32'h1000, 32'h8001_7FFF, 1, 32'h0000_7FFF);
    run_a(F3_LB,  32'h1001, 32'h80FF_1234, 0, 32'h0000_0012);
    run_a(F3_LH,  32'h1000, 32'h0000_8000, 2, 32'hFFFF_8000);
    run_a(F3_LW,  32'h1004, 32'h1234_5678, 0, 32'h1234_5678);

    // Faults
    fault_a_case(F3_LW, 32'h1001, FC_MISALIGNED);
    fault_a_case(F3_LD, 32'h1000, FC_ILLEGAL);
    fault_a_case(F3_LH, 32'h1003, FC_MISALIGNED);
    fault_a_case(3'b111, 32'h1000, FC_ILLEGAL);
    fault_a_case(F3_LWU, 32'h1000, FC_ILLEGAL);

    // Flush in IDLE suppresses both faults and acceptance
    @(negedge clk);
    load_en_a = 1'b1; funct3_a = F3_LD; addr_a = 32'h1000; flush_a = 1'b1;
    #1 check("idle_flush_stall", 64'(stall_a), 64'd0);
    @(negedge clk);
    funct3_a = F3_LW;
    check("idle_flush_no_fault", 64'(fault_a), 64'd0);
    #1 check("idle_flush_stall_legal", 64'(stall_a), 64'd0);
    @(negedge clk);
    load_en_a = 1'b0; flush_a = 1'b0;
    check("idle_flush_no_read", 64'(mem_read_a), 64'd0);
    check("idle_flush_cause_held", 64'(fault_cause_a), 64'(FC_ILLEGAL));

    // Timeout
    busy_a = 100;
    @(negedge clk);
    load_en_a = 1'b1; funct3_a = F3_LW; addr_a = 32'h1000;
    at = 0; rd_n = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i == 1) load_en_a = 1'b0;
      if (fault_a) begin
        at = i;
        break;
      end
      if (mem_read_a) rd_n++;
    end
    check("timeout_cycle", 64'(at), 64'd5);
    check("timeout_read_cycles", 64'(rd_n), 64'd4);
    check("timeout_cause", 64'(fault_cause_a), 64'(FC_TIMEOUT));
    check("timeout_state", 64'(dbg_state_a), 64'(ST_IDLE));
    check("timeout_read_low", 64'(mem_read_a), 64'd0);

    // Flush in READ; LOAD_EN during READ ignored
    prev = load_data_a;
    busy_a = 3;
    mem_rdata_a = 32'hCAFE_F00D;
    @(negedge clk);
    load_en_a = 1'b1; funct3_a = F3_LW; addr_a = 32'h1008;
    rd_n = 0; v_n = 0; f_n = 0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (i == 1) funct3_a = F3_LD;
      if (i == 2) flush_a = 1'b1;
      if (i == 3) flush_a = 1'b0;
      if (i == 4) load_en_a = 1'b0;
      if (mem_read_a) rd_n++;
      if (load_valid_a) v_n++;
      if (fault_a) f_n++;
    end
    check("flush_read_cycles", 64'(rd_n), 64'd4);
    check("flush_no_valid", 64'(v_n), 64'd0);
    check("flush_no_fault", 64'(f_n), 64'd0);
    check("flush_data_kept", 64'(load_data_a), 64'(prev));
    run_a(F3_LW, 32'h100C, 32'h0BAD_F00D, 0, 32'h0BAD_F00D);

    // Random loads against the byte-wise model
    for (int n = 0; n < 10; n++) begin
      logic [2:0] f3;
      int off;
      logic [31:0] rd;
      f3  = f3s[$urandom_range(0, 4)];
      off = $urandom_range(0, 3);
      if (f3[1:0] == 2'b01) off = off & 2;
      if (f3[1:0] == 2'b10) off = 0;
      rd  = $urandom;
      run_a(f3, 32'h3000 + 32'(4 * $urandom_range(0, 15) + off), rd,
            $urandom_range(0, 3), 32'(model(32, f3, off, {32'b0, rd})));
    end

    // 64-bit instance
    run_b(F3_LWU, 32'h2004, 64'hDEAD_BEEF_0000_0001, 64'h0000_0000_DEAD_BEEF);
    run_b(F3_LW,  32'h2004, 64'hDEAD_BEEF_0000_0001, 64'hFFFF_FFFF_DEAD_BEEF);
    run_b(F3_LD,  32'h2008, 64'hDEAD_BEEF_0000_0001, 64'hDEAD_BEEF_0000_0001);
    run_b(F3_LB,  32'h2007, 64'hDEAD_BEEF_0000_0001, 64'hFFFF_FFFF_FFFF_FFDE);
    run_b(F3_LHU, 32'h2006, 64'hDEAD_BEEF_0000_0001, 64'h0000_0000_0000_DEAD);

    // Reset during READ abandons the transaction
    busy_b = 50;
    @(negedge clk);
    load_en_b = 1'b1; funct3_b = F3_LD; addr_b = 32'h2000;
    @(negedge clk);
    load_en_b = 1'b0;
    check("b_read_active", 64'(mem_read_b), 64'd1);
    @(negedge clk);
    rst_b = 1'b1;
    #1 check("b_reset_read_drop", 64'(mem_read_b), 64'd0);
    check("b_reset_stall", 64'(stall_b), 64'd0);
    @(negedge clk);
    rst_b = 1'b0;
    v_n = 0;
    repeat (6) begin
      @(negedge clk);
      if (load_valid_b) v_n++;
    end
    check("b_reset_no_valid", 64'(v_n), 64'd0);
    check("b_reset_state", 64'(dbg_state_b), 64'(ST_IDLE));

    check("exp_q_drained", 64'(exp_q.size()), 64'd0);
    check("exp64_q_drained", 64'(exp64_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
